// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and baud divider helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    function automatic int baud_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVERSAMPLE);
        return d < 1 ? 1 : d;
    endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: valid/ready byte stream from the receiver to its consumer
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    modport master(output rx_data, rx_valid, input rx_ready);
    modport slave(input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through synchronous FIFO, head visible on rdata
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign rdata = mem[rptr];
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot a full FIFO needs for the push
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem <= '{default: '0};
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 UART receiver feeding an FWFT byte FIFO
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic srx,
    uart_rx_core_if.master rx,
    output logic frame_err,
    output logic overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    rx_state_e state;
    logic s_meta, s_sync, s_prev;
    logic start, tick, push, full, empty;
    logic [DW-1:0] dcnt;
    logic [3:0] tcnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    assign start = state == IDLE && !s_sync && s_prev;
    assign tick = dcnt == DW'(DIV - 1);
    assign rx.rx_valid = !empty;
    assign overrun = push && full && !rx.rx_ready;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_meta <= 1'b1;
            s_sync <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s_meta <= srx;
            s_sync <= s_meta;
            s_prev <= s_sync;
        end
    end
    // restart the divider on the start edge so sampling is phase-aligned to the frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) dcnt <= '0;
        else dcnt <= (start || tick) ? '0 : dcnt + 1'b1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tcnt <= '0;
            bcnt <= '0;
            shreg <= '0;
            push <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= START;
                    tcnt <= '0;
                end
                START: if (tick) begin
                    if (tcnt == 4'(MID_SAMPLE)) begin
                        tcnt <= '0;
                        bcnt <= '0;
                        state <= s_sync ? IDLE : DATA;
                    end else tcnt <= tcnt + 4'd1;
                end
                DATA: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        shreg[bcnt] <= s_sync;
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) state <= STOP;
                    end
                end
                STOP: if (tick) begin
                    tcnt <= tcnt + 4'd1;
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        push <= s_sync;
                        frame_err <= !s_sync;
                        state <= s_sync ? IDLE : BREAK;
                    end
                end
                BREAK: if (s_sync) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(rx.rx_ready),
        .wdata(shreg),
        .rdata(rx.rx_data),
        .full(full),
        .empty(empty),
        .count(fifo_cnt)
    );
endmodule
